// File: rtl/gate_deadtime_pkg.sv
// Shared types for the gate dead-time block: per-phase FSM states, request
// encoding and the default dead-time width.
package gate_deadtime_pkg;

  localparam int unsigned DtWDefault = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDt   = 2'd1,
    StHOn  = 2'd2,
    StLOn  = 2'd3
  } phase_state_e;

  typedef enum logic [1:0] {
    ReqNone    = 2'd0,
    ReqH       = 2'd1,
    ReqL       = 2'd2,
    ReqIllegal = 2'd3
  } req_e;

  // Decode one phase's registered high/low command pair.
  function automatic req_e decode_req(input logic vh, input logic vl);
    req_e r;
    case ({vh, vl})
      2'b10:   r = ReqH;
      2'b01:   r = ReqL;
      2'b11:   r = ReqIllegal;
      default: r = ReqNone;
    endcase
    return r;
  endfunction

  // ON state that corresponds to a legal side request.
  function automatic phase_state_e on_state(input req_e r);
    phase_state_e s;
    case (r)
      ReqH:    s = StHOn;
      ReqL:    s = StLOn;
      default: s = StIdle;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gate_phase.sv
// One half-bridge phase: input register, request decode, dead-time counter
// and the IDLE/DT/H_ON/L_ON sequencer that guarantees break-before-make.
module gate_phase
  import gate_deadtime_pkg::*;
#(
  parameter int unsigned DT_W = DtWDefault
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            force_idle_i,
  input  logic            vh_i,
  input  logic            vl_i,
  input  logic [DT_W-1:0] dead_time_i,
  output logic            gh_o,
  output logic            gl_o,
  output logic            dt_active_o,
  output logic            illegal_o
);

  logic            vh_q, vl_q;
  req_e            req, req_eff;
  phase_state_e    state_q, state_d;
  req_e            tgt_q, tgt_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] reload;

  // Register the commands once before decode.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vh_q <= 1'b0;
      vl_q <= 1'b0;
    end else begin
      vh_q <= vh_i;
      vl_q <= vl_i;
    end
  end

  // Decode; an illegal pair behaves as no request.
  always_comb begin
    req       = decode_req(vh_q, vl_q);
    req_eff   = (req == ReqIllegal) ? ReqNone : req;
    illegal_o = (req == ReqIllegal);
  end

  // A side swap always passes through DT; a zero dead time still costs one
  // cycle there so the counter never starts at zero and wraps.
  assign reload = (dead_time_i == '0) ? DT_W'(1) : dead_time_i;

  // Next-state logic for the phase sequencer and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (force_idle_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      tgt_d   = ReqNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_eff != ReqNone) begin
            if (dead_time_i == '0) begin
              state_d = on_state(req_eff);
            end else begin
              state_d = StDt;
              cnt_d   = dead_time_i;
              tgt_d   = req_eff;
            end
          end
        end
        StDt: begin
          if (req_eff == ReqNone) begin
            state_d = StIdle;
          end else if (req_eff != tgt_q) begin
            cnt_d = reload;
            tgt_d = req_eff;
          end else if (cnt_q == DT_W'(1)) begin
            state_d = on_state(tgt_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        StHOn: begin
          if (req_eff == ReqL) begin
            state_d = StDt;
            cnt_d   = reload;
            tgt_d   = ReqL;
          end else if (req_eff != ReqH) begin
            state_d = StIdle;
          end
        end
        StLOn: begin
          if (req_eff == ReqH) begin
            state_d = StDt;
            cnt_d   = reload;
            tgt_d   = ReqH;
          end else if (req_eff != ReqL) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counter and target registers; reset drops the gates at once.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tgt_q   <= ReqNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Gate drives decode straight from the state register.
  always_comb begin
    gh_o        = (state_q == StHOn);
    gl_o        = (state_q == StLOn);
    dt_active_o = (state_q == StDt);
  end

endmodule

// File: rtl/gate_deadtime.sv
// Three-phase gate driver with dead-time insertion, overcurrent shutdown and
// sticky shoot-through detection.
module gate_deadtime
  import gate_deadtime_pkg::*;
#(
  parameter int unsigned DT_W = DtWDefault
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            en,
  input  logic [2:0]      VH_in,
  input  logic [2:0]      VL_in,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault_n,
  input  logic            fault_clr,
  output logic [2:0]      GH,
  output logic [2:0]      GL,
  output logic            fault,
  output logic            shoot_thru,
  output logic [2:0]      dt_active
);

  logic       fault_meta_q, fault_s_q;
  logic       fault_q, fault_d;
  logic       shoot_q, shoot_d;
  logic       force_idle;
  logic [2:0] illegal;

  // Two-flop synchronizer for the asynchronous overcurrent input.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fault_meta_q <= 1'b1;
      fault_s_q    <= 1'b1;
    end else begin
      fault_meta_q <= fault_n;
      fault_s_q    <= fault_meta_q;
    end
  end

  // Sticky flags: clear requests lose against a still-present cause.
  always_comb begin
    fault_d = fault_q;
    shoot_d = shoot_q;
    if (!fault_s_q) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
    if (|illegal) begin
      shoot_d = 1'b1;
    end else if (fault_clr) begin
      shoot_d = 1'b0;
    end
  end

  // Flag registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fault_q <= 1'b0;
      shoot_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
      shoot_q <= shoot_d;
    end
  end

  // The synchronized fault forces IDLE even before the sticky flag sets.
  assign force_idle = ~en | fault_q | ~fault_s_q;
  assign fault      = fault_q;
  assign shoot_thru = shoot_q;

  for (genvar p = 0; p < 3; p++) begin : g_phase
    gate_phase #(
      .DT_W(DT_W)
    ) u_phase (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .force_idle_i(force_idle),
      .vh_i        (VH_in[p]),
      .vl_i        (VL_in[p]),
      .dead_time_i (dead_time),
      .gh_o        (GH[p]),
      .gl_o        (GL[p]),
      .dt_active_o (dt_active[p]),
      .illegal_o   (illegal[p])
    );
  end

endmodule

// File: tb/tb_gate_deadtime.sv
// Scoreboard bench for gate_deadtime: a behavioural model predicts the
// outputs after each clock edge; a monitor compares them one edge later.
module tb_gate_deadtime;
  localparam int DT_W = 8;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic            en = 1'b0;
  logic [2:0]      VH_in = '0, VL_in = '0;
  logic [DT_W-1:0] dead_time = '0;
  logic            fault_n = 1'b1, fault_clr = 1'b0;
  logic [2:0]      GH, GL, dt_active;
  logic            fault, shoot_thru;

  gate_deadtime #(.DT_W(DT_W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .en        (en),
    .VH_in     (VH_in),
    .VL_in     (VL_in),
    .dead_time (dead_time),
    .fault_n   (fault_n),
    .fault_clr (fault_clr),
    .GH        (GH),
    .GL        (GL),
    .fault     (fault),
    .shoot_thru(shoot_thru),
    .dt_active (dt_active)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [2:0] gh;
    logic [2:0] gl;
    logic [2:0] dta;
    logic       flt;
    logic       sht;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stimulus held for the next edge.
  logic            cur_en = 1'b0, cur_fn = 1'b1, cur_clr = 1'b0;
  logic [2:0]      cur_vh = '0, cur_vl = '0;
  logic [DT_W-1:0] cur_dt = '0;

  // Outputs sampled mid-cycle by the stimulus process.
  logic [2:0] s_gh, s_gl, s_dta;
  logic       s_flt, s_sht;

  // Reference model: each phase is either on (side 1=H, 2=L), waiting out a
  // dead time toward a side, or idle. Inputs reach it one edge late.
  int         m_on[3] = '{0, 0, 0};
  int         m_ws[3] = '{0, 0, 0};
  int         m_wl[3] = '{0, 0, 0};
  logic [2:0] m_vhq = '0, m_vlq = '0;
  logic       m_meta = 1'b1, m_fs = 1'b1, m_flt = 1'b0, m_sht = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    bit   frc;
    int   r, dt, hold;
    exp_t x;
    frc  = !cur_en || m_flt || !m_fs;
    dt   = int'(cur_dt);
    hold = (dt == 0) ? 1 : dt;
    for (int p = 0; p < 3; p++) begin
      if (m_vhq[p] && !m_vlq[p]) r = 1;
      else if (m_vlq[p] && !m_vhq[p]) r = 2;
      else r = 0;
      if (frc) begin
        m_on[p] = 0;
        m_ws[p] = 0;
      end else if (m_on[p] != 0) begin
        if (r != m_on[p]) begin
          m_on[p] = 0;
          if (r != 0) begin
            m_ws[p] = r;
            m_wl[p] = hold;
          end
        end
      end else if (m_ws[p] != 0) begin
        if (r == 0) m_ws[p] = 0;
        else if (r != m_ws[p]) begin
          m_ws[p] = r;
          m_wl[p] = hold;
        end else if (m_wl[p] == 1) begin
          m_on[p] = r;
          m_ws[p] = 0;
        end else m_wl[p] = m_wl[p] - 1;
      end else if (r != 0) begin
        if (dt == 0) m_on[p] = r;
        else begin
          m_ws[p] = r;
          m_wl[p] = dt;
        end
      end
    end
    if (!m_fs) m_flt = 1'b1;
    else if (cur_clr) m_flt = 1'b0;
    if ((m_vhq & m_vlq) != 3'b000) m_sht = 1'b1;
    else if (cur_clr) m_sht = 1'b0;
    m_fs   = m_meta;
    m_meta = cur_fn;
    m_vhq  = cur_vh;
    m_vlq  = cur_vl;
    for (int p = 0; p < 3; p++) begin
      x.gh[p]  = (m_on[p] == 1);
      x.gl[p]  = (m_on[p] == 2);
      x.dta[p] = (m_ws[p] != 0);
    end
    x.flt = m_flt;
    x.sht = m_sht;
    exp_q.push_back(x);
  endtask

  // One cycle: sample outputs, apply the held stimulus, predict the next edge.
  task automatic tick();
    @(negedge HCLK);
    s_gh  = GH;
    s_gl  = GL;
    s_dta = dt_active;
    s_flt = fault;
    s_sht = shoot_thru;
    en        = cur_en;
    VH_in     = cur_vh;
    VL_in     = cur_vl;
    dead_time = cur_dt;
    fault_n   = cur_fn;
    fault_clr = cur_clr;
    model_step();
  endtask

  // Cycles until the chosen gate of a phase is seen high; -1 if it never is.
  task automatic measure(input int ph, input bit high, output int lat, output int dta);
    lat = 0;
    dta = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      lat++;
      if (s_dta[ph]) dta++;
      if (high ? s_gh[ph] : s_gl[ph]) return;
    end
    lat = -1;
  endtask

  // Monitor: one prediction per edge, plus the no-overlap invariant.
  exp_t e, got;
  always @(posedge HCLK) begin
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = '{gh: GH, gl: GL, dta: dt_active, flt: fault, sht: shoot_thru};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: got GH=%b GL=%b dt=%b flt=%b st=%b, want GH=%b GL=%b dt=%b flt=%b st=%b",
                 $time, got.gh, got.gl, got.dta, got.flt, got.sht,
                 e.gh, e.gl, e.dta, e.flt, e.sht);
      end
      n_cmp++;
      if ((GH & GL) != 3'b000) begin
        n_bad++;
        $display("FAIL overlap t=%0t: got GH&GL=%b, want 000", $time, GH & GL);
      end
    end
  end

  initial begin
    int lat, dta, fall, rise, pulses, saw;
    #12;
    chk("reset_gh", GH, 0);
    chk("reset_gl", GL, 0);
    chk("reset_dta", dt_active, 0);
    chk("reset_fault", fault, 0);
    chk("reset_shoot", shoot_thru, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    cur_en = 1'b1;
    cur_dt = 8'd5;
    repeat (4) tick();

    // dead_time=5 turn-on from IDLE
    cur_vh = 3'b001;
    tick();
    measure(0, 1'b1, lat, dta);
    chk("on_lat_dt5", lat, 7);
    chk("dt_len_dt5", dta, 5);

    // H -> L swap with dead_time=3
    cur_vh = '0;
    cur_dt = 8'd3;
    repeat (3) tick();
    cur_vh = 3'b001;
    tick();
    measure(0, 1'b1, lat, dta);
    chk("on_lat_dt3", lat, 5);
    cur_vh = 3'b000;
    cur_vl = 3'b001;
    tick();
    fall = -1;
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (fall < 0 && !s_gh[0]) fall = i;
      if (rise < 0 && s_gl[0]) rise = i;
    end
    chk("swap_gh_fall", fall, 2);
    chk("swap_gl_rise", rise, 5);

    // H request withdrawn mid dead-time
    cur_vl = '0;
    repeat (4) tick();
    cur_dt = 8'd4;
    cur_vh = 3'b001;
    repeat (3) tick();
    cur_vh = 3'b000;
    pulses = 0;
    saw = 0;
    repeat (12) begin
      tick();
      if (s_gh[0]) pulses++;
      if (s_dta[0]) saw = 1;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_saw_dt", saw, 1);
    chk("abort_idle", s_dta[0], 0);

    // Illegal command on phase B
    cur_vh = 3'b010;
    cur_vl = 3'b010;
    repeat (4) tick();
    chk("illegal_shoot", s_sht, 1);
    chk("illegal_gates", {s_gh[1], s_gl[1]}, 0);
    cur_clr = 1'b1;
    tick();
    cur_clr = 1'b0;
    tick();
    chk("illegal_clr_blocked", s_sht, 1);
    cur_vh = '0;
    cur_vl = '0;
    repeat (3) tick();
    chk("shoot_sticky", s_sht, 1);
    cur_clr = 1'b1;
    tick();
    cur_clr = 1'b0;
    tick();
    chk("shoot_cleared", s_sht, 0);

    // Overcurrent with all phases on
    cur_dt = 8'd2;
    cur_vh = 3'b111;
    tick();
    measure(0, 1'b1, lat, dta);
    tick();
    chk("all_on", s_gh, 3'b111);
    cur_fn = 1'b0;
    tick();
    cur_fn = 1'b1;
    repeat (3) tick();
    chk("fault_gh_off", s_gh, 0);
    chk("fault_gl_off", s_gl, 0);
    chk("fault_set", s_flt, 1);
    cur_fn = 1'b0;
    repeat (3) tick();
    cur_clr = 1'b1;
    tick();
    cur_clr = 1'b0;
    tick();
    chk("fault_clr_held", s_flt, 1);
    cur_fn = 1'b1;
    repeat (3) tick();
    cur_clr = 1'b1;
    tick();
    cur_clr = 1'b0;
    measure(0, 1'b1, lat, dta);
    chk("fault_cleared", s_flt, 0);
    chk("restart_lat", lat, 4);

    // Latency extremes
    cur_vh = '0;
    repeat (4) tick();
    cur_dt = 8'd0;
    cur_vh = 3'b001;
    tick();
    measure(0, 1'b1, lat, dta);
    chk("on_lat_dt0", lat, 2);
    cur_vh = '0;
    repeat (4) tick();
    cur_dt = 8'd255;
    cur_vh = 3'b001;
    tick();
    measure(0, 1'b1, lat, dta);
    chk("on_lat_dt255", lat, 257);
    chk("dt_len_dt255", dta, 255);
    repeat (3) tick();
    chk("dt255_holds", s_gh[0], 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      if ($urandom_range(0, 15) == 0) cur_dt = 8'($urandom_range(0, 6));
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 7) == 0) begin
          k = $urandom_range(0, 39);
          cur_vh[p] = (k == 0) || (k < 14);
          cur_vl[p] = (k == 0) || (k >= 14 && k < 27);
        end
      end
      cur_en  = ($urandom_range(0, 99) != 0);
      cur_fn  = ($urandom_range(0, 249) != 0);
      cur_clr = ($urandom_range(0, 23) == 0);
      tick();
    end

    // Asynchronous reset while gates are on
    cur_en = 1'b1;
    cur_fn = 1'b1;
    cur_dt = 8'd2;
    cur_vh = 3'b111;
    cur_vl = '0;
    repeat (4) tick();
    cur_clr = 1'b1;
    tick();
    cur_clr = 1'b0;
    repeat (12) tick();
    chk("pre_reset_on", s_gh, 3'b111);
    @(posedge HCLK);
    #3;
    chk("sb_drained", exp_q.size(), 0);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_gh", GH, 0);
    chk("async_rst_gl", GL, 0);
    chk("async_rst_dta", dt_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_deadtime.md
GATE_DEADTIME -- requirements
Module: gate_deadtime

Interface
REQ-001 Parameter DT_W, default 8, SHALL set the width of the dead-time value and the per-phase counter.
REQ-002 HCLK  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 HRESETn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 en  input  1  SHALL enable gate drive; low forces all gates off.
REQ-005 VH_in  input  3  SHALL carry the high-side commands from the commutation controller, one bit per phase (bit0 = phase A).
REQ-006 VL_in  input  3  SHALL carry the low-side commands, same bit mapping as VH_in.
REQ-007 dead_time  input  DT_W  SHALL give the dead time in HCLK cycles.
REQ-008 fault_n  input  1  SHALL be the external overcurrent input: asynchronous, active-low.
REQ-009 fault_clr  input  1  SHALL be a single-cycle request to clear the sticky flags.
REQ-010 GH  output  3  SHALL drive the high-side gates, registered.
REQ-011 GL  output  3  SHALL drive the low-side gates, registered.
REQ-012 fault  output  1  SHALL be the sticky overcurrent flag.
REQ-013 shoot_thru  output  1  SHALL be the sticky flag for an illegal command (VH and VL both high on one phase).
REQ-014 dt_active  output  3  SHALL be high per phase while that phase is in state DT.

Function
REQ-015 VH_in and VL_in SHALL be registered once (VH_q, VL_q) before decode.
REQ-016 Per-phase request SHALL decode as follows:
- H when VH_q=1, VL_q=0.
- L when VL_q=1, VH_q=0.
- NONE when both are 0.
- ILLEGAL when both are 1; ILLEGAL SHALL be treated as NONE and SHALL set shoot_thru.
REQ-017 Each phase SHALL run an independent FSM with states IDLE, DT, H_ON, L_ON; GH = (state==H_ON), GL = (state==L_ON).
REQ-018 IDLE with request H or L: if dead_time==0 SHALL go directly to H_ON or L_ON; else SHALL go to DT with tgt=request and cnt=dead_time.
REQ-019 DT: cnt SHALL decrement each cycle. The phase SHALL enter tgt's ON state on the edge where cnt==1 and request==tgt.
REQ-020 DT with request NONE SHALL return to IDLE; DT with the opposite request SHALL reload cnt=dead_time and update tgt.
REQ-021 H_ON or L_ON with any other request SHALL leave ON on the next edge, going to IDLE for NONE or DT for the opposite side. The ON gate therefore drops in the same edge.
REQ-022 Dead time SHALL be inserted before every turn-on, including from IDLE.
REQ-023 Latency: turn-on = 2 + dead_time cycles from the VH_in/VL_in change; turn-off = 2 cycles.
REQ-024 GH[n] and GL[n] SHALL never be high simultaneously under any input sequence.
REQ-025 dead_time SHALL be sampled only when cnt is loaded; changes during DT SHALL not affect the running count.
REQ-026 fault_n SHALL pass through a 2-flop synchronizer (fault_s). fault SHALL set on the edge after fault_s goes low.
REQ-027 While fault=1 or fault_s=0, all phases SHALL be forced to IDLE. GH and GL SHALL be 0 no later than 3 cycles after fault_n falls.
REQ-028 fault_clr SHALL clear fault only when fault_s=1. If fault_clr coincides with fault_s=0, fault SHALL remain set.
REQ-029 fault_clr SHALL clear shoot_thru unconditionally, unless ILLEGAL is present in the same cycle; in that case shoot_thru stays set.
REQ-030 en=0 SHALL force all phases to IDLE and SHALL leave fault and shoot_thru unchanged.
REQ-031 After en rises or fault clears, phases SHALL restart from IDLE with full dead time.
REQ-032 dead_time at maximum (2^DT_W-1) SHALL count fully, with no wrap.

Reset
REQ-033 On HRESETn low, the block SHALL reset as follows:
- All FSMs to IDLE.
- cnt, tgt, VH_q and VL_q to 0.
- Synchronizer flops to 1 (no fault).
- fault=0, shoot_thru=0, GH=GL=dt_active=0.
REQ-034 Assertion of HRESETn mid-dead-time or mid-ON SHALL drop all gates immediately (asynchronously).

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE, DT, H_ON, L_ON), the request encoding and the DT_W default.
REQ-036 The per-phase FSM, counter and decode SHALL be the sub-module gate_phase, instantiated 3 times. Flags and the synchronizer SHALL stay in the top level.

Verification
REQ-037 dead_time=5, VH_in[0] 0->1 -> GH[0] rises exactly 7 cycles later; dt_active[0] high for 5 cycles.
REQ-038 Phase A in H_ON, dead_time=3, VH_in/VL_in switch H->L -> GH[0] falls at +2 and GL[0] rises at +5; both are 0 in between.
REQ-039 dead_time=4, H request withdrawn after 2 DT cycles -> phase returns to IDLE and GH[0] never pulses.
REQ-040 VH_in=VL_in=3'b010 -> GH[1]=GL[1]=0 and shoot_thru=1 stays set. fault_clr with legal inputs clears it.
REQ-041 All phases ON, fault_n low for 1 cycle -> all gates 0 within 3 cycles and fault=1. fault_clr while fault_n is still low leaves fault=1; fault_clr after release clears it and gates restart after 2+dead_time cycles.
REQ-042 dead_time=0 -> turn-on latency 2. dead_time=255 -> turn-on latency 257. Check for no counter wrap.
